// File: rtl/array_counter_arb.sv
// array_counter_arb: round-robin front end that merges R requesters onto the
// counter array's single inc lane and single dec lane. It also sequences a
// drain-then-clear of the array through the array's cnt_rst input.
//
// Handshake: an event from requester r is transferred in a cycle where
// i_req_valid[r] and o_req_ready[r] are both 1. o_req_ready is combinational.
// Requesters keep valid/op/id stable until they see ready. The accepted event
// appears on the matching lane strobe one cycle later.
module array_counter_arb #(
   parameter int R   = 4,
   parameter int N   = 8,
   parameter int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [R-1:0]   i_req_valid,
   input  logic [R-1:0]   i_req_op,
   input  logic [IDW-1:0] i_req_id [R],
   output logic [R-1:0]   o_req_ready,
   input  logic           i_pause,
   input  logic           i_clr_req,
   output logic           o_inc,
   output logic [IDW-1:0] o_inc_id,
   output logic           o_dec,
   output logic [IDW-1:0] o_dec_id,
   output logic           o_cnt_rst,
   output logic           o_busy,
   output logic           o_clr_done,
   output logic [1:0]     o_state
);

   localparam int PW = (R > 1) ? $clog2(R) : 1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [PW-1:0]  r_inc_ptr;
   logic [PW-1:0]  r_dec_ptr;
   logic           r_inc;
   logic [IDW-1:0] r_inc_id;
   logic           r_dec;
   logic [IDW-1:0] r_dec_id;
   logic           r_clr_done;

   logic           w_en;
   logic [R-1:0]   w_inc_cand;
   logic [R-1:0]   w_dec_cand;
   logic [R-1:0]   w_inc_gnt;
   logic [R-1:0]   w_dec_gnt;
   logic           w_inc_any;
   logic           w_dec_any;
   logic [PW-1:0]  w_inc_ptr_nxt;
   logic [PW-1:0]  w_dec_ptr_nxt;
   logic [IDW-1:0] w_inc_gid;
   logic [IDW-1:0] w_dec_gid;

   // Grants only while running, not paused and out of reset.
   assign w_en       = rst_n & (r_state == ST_RUN) & ~i_pause;
   assign w_inc_cand = i_req_valid & i_req_op & {R{w_en}};
   assign w_dec_cand = i_req_valid & ~i_req_op & {R{w_en}};

   // Inc lane round-robin: first pass picks a candidate at/above the pointer,
   // second pass wraps around to the candidates below it.
   always_comb begin
      w_inc_gnt     = '0;
      w_inc_any     = 1'b0;
      w_inc_ptr_nxt = r_inc_ptr;
      w_inc_gid     = '0;
      for (int j = 0; j < R; j++) begin
         if (!w_inc_any && w_inc_cand[j] && (j >= int'(r_inc_ptr))) begin
            w_inc_any     = 1'b1;
            w_inc_gnt[j]  = 1'b1;
            w_inc_ptr_nxt = PW'((j + 1) % R);
            w_inc_gid     = i_req_id[j];
         end
      end
      for (int j = 0; j < R; j++) begin
         if (!w_inc_any && w_inc_cand[j]) begin
            w_inc_any     = 1'b1;
            w_inc_gnt[j]  = 1'b1;
            w_inc_ptr_nxt = PW'((j + 1) % R);
            w_inc_gid     = i_req_id[j];
         end
      end
   end

   // Dec lane round-robin, same two-pass scheme with its own pointer.
   always_comb begin
      w_dec_gnt     = '0;
      w_dec_any     = 1'b0;
      w_dec_ptr_nxt = r_dec_ptr;
      w_dec_gid     = '0;
      for (int j = 0; j < R; j++) begin
         if (!w_dec_any && w_dec_cand[j] && (j >= int'(r_dec_ptr))) begin
            w_dec_any     = 1'b1;
            w_dec_gnt[j]  = 1'b1;
            w_dec_ptr_nxt = PW'((j + 1) % R);
            w_dec_gid     = i_req_id[j];
         end
      end
      for (int j = 0; j < R; j++) begin
         if (!w_dec_any && w_dec_cand[j]) begin
            w_dec_any     = 1'b1;
            w_dec_gnt[j]  = 1'b1;
            w_dec_ptr_nxt = PW'((j + 1) % R);
            w_dec_gid     = i_req_id[j];
         end
      end
   end

   assign o_req_ready = w_inc_gnt | w_dec_gnt;

   // Clear sequencer next state: RUN -> DRAIN -> CLEAR -> RUN.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:   if (i_clr_req) w_state_nxt = ST_DRAIN;
         ST_DRAIN: w_state_nxt = ST_CLEAR;
         ST_CLEAR: w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_RUN;
      endcase
   end

   // State, pointers, lane output registers and the clear-done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_RUN;
         r_inc_ptr  <= '0;
         r_dec_ptr  <= '0;
         r_inc      <= 1'b0;
         r_inc_id   <= '0;
         r_dec      <= 1'b0;
         r_dec_id   <= '0;
         r_clr_done <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_inc      <= w_inc_any;
         r_dec      <= w_dec_any;
         r_clr_done <= (r_state == ST_CLEAR);
         if (w_inc_any) begin
            r_inc_ptr <= w_inc_ptr_nxt;
            r_inc_id  <= w_inc_gid;
         end
         if (w_dec_any) begin
            r_dec_ptr <= w_dec_ptr_nxt;
            r_dec_id  <= w_dec_gid;
         end
      end
   end

   assign o_inc      = r_inc;
   assign o_inc_id   = r_inc_id;
   assign o_dec      = r_dec;
   assign o_dec_id   = r_dec_id;
   assign o_cnt_rst  = (r_state == ST_CLEAR);
   assign o_busy     = (r_state != ST_RUN);
   assign o_clr_done = r_clr_done;
   assign o_state    = r_state;

endmodule

// File: tb/tb_array_counter_arb.sv
// Bench for array_counter_arb: directed scenarios followed by random traffic,
// every cycle checked against a behavioural model of the arbitration rules.
module tb_array_counter_arb;

  localparam int R   = 4;
  localparam int N   = 8;
  localparam int IDW = $clog2(N);
  localparam int W   = 2 + 2 * IDW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT (R=4) ----------------
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_op;
  logic [IDW-1:0] req_id [R];
  logic [R-1:0]   req_ready;
  logic           pause;
  logic           clr_req;
  logic           inc, dec, cnt_rst, busy, clr_done;
  logic [IDW-1:0] inc_id, dec_id;
  logic [1:0]     state;

  array_counter_arb #(.R(R), .N(N)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_op(req_op), .i_req_id(req_id),
    .o_req_ready(req_ready), .i_pause(pause), .i_clr_req(clr_req),
    .o_inc(inc), .o_inc_id(inc_id), .o_dec(dec), .o_dec_id(dec_id),
    .o_cnt_rst(cnt_rst), .o_busy(busy), .o_clr_done(clr_done), .o_state(state)
  );

  // ---------------- DUT (R=1) ----------------
  logic           s_valid, s_op, s_ready, s_inc, s_dec, s_cnt_rst, s_busy, s_clr_done;
  logic [IDW-1:0] s_id [1];
  logic [IDW-1:0] s_inc_id, s_dec_id;
  logic [1:0]     s_state;

  array_counter_arb #(.R(1), .N(N)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(s_valid), .i_req_op(s_op), .i_req_id(s_id),
    .o_req_ready(s_ready), .i_pause(pause), .i_clr_req(clr_req),
    .o_inc(s_inc), .o_inc_id(s_inc_id), .o_dec(s_dec), .o_dec_id(s_dec_id),
    .o_cnt_rst(s_cnt_rst), .o_busy(s_busy), .o_clr_done(s_clr_done), .o_state(s_state)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int m_inc_ptr, m_dec_ptr, m_phase;   // phase: 0 run, 1 drain, 2 clear
  logic [IDW-1:0] m_inc_id, m_dec_id;
  logic [R-1:0] m_last_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [R-1:0] cand, input int ptr);
    for (int k = 0; k < R; k++) begin
      if (cand[(ptr + k) % R]) return (ptr + k) % R;
    end
    return -1;
  endfunction

  task automatic reset_model();
    m_inc_ptr  = 0;
    m_dec_ptr  = 0;
    m_phase    = 0;
    m_inc_id   = '0;
    m_dec_id   = '0;
    m_last_gnt = '0;
    exp_q.delete();
  endtask

  // One clock cycle: called at posedge+1 with inputs already applied.
  task automatic cycle();
    logic [R-1:0] ci, cd, er;
    int gi, gd;
    logic clr_in;
    logic exp_done;
    #4;
    ci = '0; cd = '0; er = '0;
    for (int r = 0; r < R; r++) begin
      ci[r] = req_valid[r] & req_op[r];
      cd[r] = req_valid[r] & ~req_op[r];
    end
    gi = -1; gd = -1;
    if (m_phase == 0 && !pause) begin
      gi = pick(ci, m_inc_ptr);
      gd = pick(cd, m_dec_ptr);
    end
    if (gi >= 0) begin er[gi] = 1'b1; m_inc_id = req_id[gi]; m_inc_ptr = (gi + 1) % R; end
    if (gd >= 0) begin er[gd] = 1'b1; m_dec_id = req_id[gd]; m_dec_ptr = (gd + 1) % R; end
    m_last_gnt = er;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy_mid", 32'(busy), 32'(m_phase != 0));
    exp_q.push_back({gi >= 0, m_inc_id, gd >= 0, m_dec_id});
    clr_in = clr_req;
    @(posedge clk);
    #1;
    exp_done = (m_phase == 2);
    if (m_phase == 0) m_phase = clr_in ? 1 : 0;
    else if (m_phase == 1) m_phase = 2;
    else m_phase = 0;
    if (exp_q.size() == 0) chk("queue_empty", 32'd1, 32'd0);
    else chk("strobes", 32'({inc, inc_id, dec, dec_id}), 32'(exp_q.pop_front()));
    chk("cnt_rst", 32'(cnt_rst), 32'(m_phase == 2));
    chk("clr_done", 32'(clr_done), 32'(exp_done));
    chk("busy", 32'(busy), 32'(m_phase != 0));
  endtask

  task automatic set_req(input int r, input logic v, input logic op, input int id);
    req_valid[r] = v;
    req_op[r]    = op;
    req_id[r]    = IDW'(id);
  endtask

  task automatic idle_all();
    for (int r = 0; r < R; r++) set_req(r, 1'b0, 1'b0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    rst_n = 1'b0; pause = 1'b0; clr_req = 1'b0;
    idle_all();
    for (int r = 0; r < R; r++) req_valid[r] = 1'b1;
    s_valid = 1'b0; s_op = 1'b0; s_id[0] = '0;
    reset_model();
    #2;
    // reset state with requests pending
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_outs", 32'({inc, inc_id, dec, dec_id, cnt_rst, busy, clr_done}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    idle_all();
    rst_n = 1'b1;

    // 1: two inc requesters held valid alternate 0,2,0,2
    set_req(0, 1'b1, 1'b1, 3);
    set_req(2, 1'b1, 1'b1, 5);
    for (int i = 0; i < 4; i++) cycle();
    chk("t1_last_id", 32'(inc_id), 32'd5);
    idle_all();
    cycle();

    // 2: same id on inc and dec lanes in one cycle
    set_req(1, 1'b1, 1'b1, 6);
    set_req(3, 1'b1, 1'b0, 6);
    cycle();
    chk("t2_both", 32'({inc, inc_id, dec, dec_id}), 32'({1'b1, 3'd6, 1'b1, 3'd6}));
    idle_all();
    cycle();

    // 3: pause with all four valid, then release
    set_req(0, 1'b1, 1'b1, 1);
    set_req(1, 1'b1, 1'b0, 2);
    set_req(2, 1'b1, 1'b1, 4);
    set_req(3, 1'b1, 1'b0, 7);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    pause = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // 4: clear pulse during traffic
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // 6: async reset while in CLEAR
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    cycle();
    chk("t6_in_clear", 32'(cnt_rst), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", 32'({inc, dec, cnt_rst, busy, clr_done}), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_model();
    for (int r = 0; r < R; r++) set_req(r, 1'b1, 1'b1, r);
    rst_n = 1'b1;
    cycle();
    chk("t6_first_gnt", 32'(m_last_gnt), 32'd1);
    for (int i = 0; i < 3; i++) cycle();
    idle_all();
    cycle();

    // random traffic; requesters hold until granted
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < R; r++) begin
        if (!req_valid[r] || m_last_gnt[r])
          set_req(r, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, N - 1)));
      end
      pause   = ($urandom_range(0, 7) == 0);
      clr_req = ($urandom_range(0, 19) == 0);
      cycle();
    end
    pause = 1'b0; clr_req = 1'b0;
    idle_all();
    for (int i = 0; i < 3; i++) cycle();

    // 5: single-requester instance, four back-to-back incs to id 2
    pulses = 0;
    s_valid = 1'b1; s_op = 1'b1; s_id[0] = 3'd2;
    for (int i = 0; i < 4; i++) begin
      #4;
      chk("t5_ready", 32'(s_ready), 32'd1);
      @(posedge clk); #1;
      chk("t5_inc", 32'({s_inc, s_inc_id}), 32'({1'b1, 3'd2}));
      if (s_inc) pulses++;
    end
    s_valid = 1'b0;
    #4;
    chk("t5_ready_off", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    chk("t5_inc_off", 32'(s_inc), 32'd0);
    chk("t5_pulses", 32'(pulses), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
